// File: rtl/execute_cycle_if.sv
// ID/EX inputs and EX/MEM outputs of the RV32I execute stage.
interface execute_cycle_if #(
   parameter int unsigned XLEN = 32
);
   localparam int unsigned REG_IDX_W = 5;

   // ID/EX bundle and hazard-unit selects
   logic                 RegWriteE;
   logic                 ALUSrcE;
   logic                 MemWriteE;
   logic                 ResultSrcE;
   logic                 BranchE;
   logic [2:0]           ALUControlE;
   logic [XLEN-1:0]      RD1_E;
   logic [XLEN-1:0]      RD2_E;
   logic [XLEN-1:0]      Imm_Ext_E;
   logic [REG_IDX_W-1:0] RD_E;
   logic [XLEN-1:0]      PCE;
   logic [XLEN-1:0]      PCPlus4E;
   logic [XLEN-1:0]      ResultW;
   logic [1:0]           ForwardA_E;
   logic [1:0]           ForwardB_E;

   // Branch resolution to fetch (combinational)
   logic                 PCSrcE;
   logic [XLEN-1:0]      PCTargetE;

   // EX/MEM pipeline register
   logic                 RegWriteM;
   logic                 MemWriteM;
   logic                 ResultSrcM;
   logic [REG_IDX_W-1:0] RD_M;
   logic [XLEN-1:0]      PCPlus4M;
   logic [XLEN-1:0]      WriteDataM;
   logic [XLEN-1:0]      ALU_ResultM;

   // Upstream side: drives the EX bundle, observes EX/MEM and branch outputs
   modport master (
      output RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, ALUControlE,
             RD1_E, RD2_E, Imm_Ext_E, RD_E, PCE, PCPlus4E, ResultW,
             ForwardA_E, ForwardB_E,
      input  PCSrcE, PCTargetE, RegWriteM, MemWriteM, ResultSrcM, RD_M,
             PCPlus4M, WriteDataM, ALU_ResultM
   );

   // Execute stage side
   modport slave (
      input  RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, ALUControlE,
             RD1_E, RD2_E, Imm_Ext_E, RD_E, PCE, PCPlus4E, ResultW,
             ForwardA_E, ForwardB_E,
      output PCSrcE, PCTargetE, RegWriteM, MemWriteM, ResultSrcM, RD_M,
             PCPlus4M, WriteDataM, ALU_ResultM
   );
endinterface

// File: rtl/execute_cycle.sv
// RV32I execute stage: operand forwarding, ALU, BEQ resolution, EX/MEM register.
module execute_cycle #(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   execute_cycle_if.slave  ex
);
   localparam int unsigned REG_IDX_W = 5;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   logic [XLEN-1:0]      src_a;
   logic [XLEN-1:0]      write_data_e;
   logic [XLEN-1:0]      src_b;
   logic [XLEN-1:0]      alu_result_e;
   logic                 zero_e;
   logic                 slt_e;

   logic                 reg_write_m;
   logic                 mem_write_m;
   logic                 result_src_m;
   logic [REG_IDX_W-1:0] rd_m;
   logic [XLEN-1:0]      pc_plus4_m;
   logic [XLEN-1:0]      write_data_m;
   logic [XLEN-1:0]      alu_result_m;

   // Forwarding muxes; select 11 falls back to the register-file value
   always_comb begin
      src_a        = ex.RD1_E;
      write_data_e = ex.RD2_E;
      case (ex.ForwardA_E)
         FWD_WB:  src_a = ex.ResultW;
         FWD_MEM: src_a = alu_result_m;
         FWD_RF:  src_a = ex.RD1_E;
         default: src_a = ex.RD1_E;
      endcase
      case (ex.ForwardB_E)
         FWD_WB:  write_data_e = ex.ResultW;
         FWD_MEM: write_data_e = alu_result_m;
         FWD_RF:  write_data_e = ex.RD2_E;
         default: write_data_e = ex.RD2_E;
      endcase
      src_b = ex.ALUSrcE ? ex.Imm_Ext_E : write_data_e;
   end

   // ALU; unused encodings produce zero
   always_comb begin
      slt_e        = ($signed(src_a) < $signed(src_b));
      alu_result_e = '0;
      case (ex.ALUControlE)
         ALU_ADD: alu_result_e = src_a + src_b;
         ALU_SUB: alu_result_e = src_a - src_b;
         ALU_AND: alu_result_e = src_a & src_b;
         ALU_OR:  alu_result_e = src_a | src_b;
         ALU_SLT: alu_result_e = XLEN'(slt_e);
         default: alu_result_e = '0;
      endcase
      zero_e = (alu_result_e == '0);
   end

   // Zero-latency branch decision and target back to fetch
   assign ex.PCSrcE    = ex.BranchE & zero_e;
   assign ex.PCTargetE = ex.PCE + ex.Imm_Ext_E;

   // EX/MEM pipeline register, free-running with async clear
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         reg_write_m  <= 1'b0;
         mem_write_m  <= 1'b0;
         result_src_m <= 1'b0;
         rd_m         <= '0;
         pc_plus4_m   <= '0;
         write_data_m <= '0;
         alu_result_m <= '0;
      end else begin
         reg_write_m  <= ex.RegWriteE;
         mem_write_m  <= ex.MemWriteE;
         result_src_m <= ex.ResultSrcE;
         rd_m         <= ex.RD_E;
         pc_plus4_m   <= ex.PCPlus4E;
         write_data_m <= write_data_e;
         alu_result_m <= alu_result_e;
      end
   end

   assign ex.RegWriteM   = reg_write_m;
   assign ex.MemWriteM   = mem_write_m;
   assign ex.ResultSrcM  = result_src_m;
   assign ex.RD_M        = rd_m;
   assign ex.PCPlus4M    = pc_plus4_m;
   assign ex.WriteDataM  = write_data_m;
   assign ex.ALU_ResultM = alu_result_m;

endmodule
